// File: rtl/character_collision_scan_pkg.sv
// Shared types and constants for the per-frame character/object collision scan.
package collision_pkg;
  localparam logic [10:0] TYPE_NONE    = 11'd0;
  localparam logic [10:0] TYPE_COIN    = 11'd102;
  localparam logic [10:0] TYPE_MONSTER = 11'd302;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic        vld;
    logic [10:0] typ;
    logic [3:0]  dir;
  } hit_t;

  // Higher value wins: monster > coin > any other solid.
  function automatic logic [1:0] class_prio(input logic [10:0] t);
    if (t == TYPE_MONSTER)   return 2'd2;
    else if (t == TYPE_COIN) return 2'd1;
    else                     return 2'd0;
  endfunction
endpackage

// File: rtl/character_collision_scan_if.sv
// Frame-start/object-table/result bundle between the scanner and its neighbours.
interface character_collision_scan_if #(
  parameter int N_OBJ   = 16,
  parameter int COORD_W = 11
) ();
  localparam int AW = $clog2(N_OBJ);

  logic               frame_start;
  logic [COORD_W-1:0] char_x, char_y;
  logic [AW-1:0]      obj_addr;
  logic               obj_valid;
  logic [COORD_W-1:0] obj_x, obj_y, obj_w, obj_h;
  logic [10:0]        obj_type;
  logic               busy, scan_done;
  logic [3:0]         Collision;
  logic [10:0]        Collision_Type;

  modport master (
    output frame_start, char_x, char_y, obj_valid, obj_x, obj_y, obj_w, obj_h, obj_type,
    input  obj_addr, busy, scan_done, Collision, Collision_Type
  );

  modport slave (
    input  frame_start, char_x, char_y, obj_valid, obj_x, obj_y, obj_w, obj_h, obj_type,
    output obj_addr, busy, scan_done, Collision, Collision_Type
  );
endinterface

// File: rtl/character_collision_scan_aabb_contact.sv
// Strict (non-touching) box overlap plus one-hot contact side by minimum penetration.
module aabb_contact
  import collision_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int CHAR_W  = 16,
  parameter int CHAR_H  = 16
) (
  input  logic [COORD_W-1:0] i_char_x,
  input  logic [COORD_W-1:0] i_char_y,
  input  logic [COORD_W-1:0] i_obj_x,
  input  logic [COORD_W-1:0] i_obj_y,
  input  logic [COORD_W-1:0] i_obj_w,
  input  logic [COORD_W-1:0] i_obj_h,
  output logic               o_hit,
  output logic [3:0]         o_dir
);
  localparam int SW = COORD_W + 1;

  logic [SW-1:0] w_cx, w_cy, w_cr, w_cb, w_ox, w_oy, w_or, w_ob;
  logic [SW-1:0] w_dr, w_dl, w_dd, w_du;

  // One extra bit keeps edge sums from wrapping near the screen limit.
  assign w_cx = {1'b0, i_char_x};
  assign w_cy = {1'b0, i_char_y};
  assign w_ox = {1'b0, i_obj_x};
  assign w_oy = {1'b0, i_obj_y};
  assign w_cr = w_cx + SW'(CHAR_W);
  assign w_cb = w_cy + SW'(CHAR_H);
  assign w_or = w_ox + {1'b0, i_obj_w};
  assign w_ob = w_oy + {1'b0, i_obj_h};

  assign o_hit = (w_cx < w_or) && (w_ox < w_cr) && (w_cy < w_ob) && (w_oy < w_cb);

  assign w_dr = w_cr - w_ox;
  assign w_dl = w_or - w_cx;
  assign w_dd = w_cb - w_oy;
  assign w_du = w_ob - w_cy;

  always_comb begin
    o_dir = '0;
    if (o_hit) begin
      if (w_dd <= w_du && w_dd <= w_dl && w_dd <= w_dr) o_dir[DIR_DOWN]  = 1'b1;
      else if (w_du <= w_dl && w_du <= w_dr)            o_dir[DIR_UP]    = 1'b1;
      else if (w_dl <= w_dr)                            o_dir[DIR_LEFT]  = 1'b1;
      else                                              o_dir[DIR_RIGHT] = 1'b1;
    end
  end
endmodule

// File: rtl/character_collision_scan.sv
// Sequential object-table scan, one slot per clock, reporting the single best hit per frame.
module character_collision_scan
  import collision_pkg::*;
#(
  parameter int N_OBJ   = 16,
  parameter int COORD_W = 11,
  parameter int CHAR_W  = 16,
  parameter int CHAR_H  = 16
) (
  input logic clk,
  input logic rst,
  character_collision_scan_if.slave bus
);
  localparam int AW     = $clog2(N_OBJ);
  localparam int STAGES = 1;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic            r_busy, r_done;
  logic [STAGES:0] r_vld_pipe;
  hit_t            r_best;
  logic [3:0]      r_col;
  logic [10:0]     r_ctype;

  logic       w_hit;
  logic [3:0] w_dir;
  hit_t       w_cur, w_nxt;

  aabb_contact #(.COORD_W(COORD_W), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H)) u_contact (
    .i_char_x (bus.char_x),
    .i_char_y (bus.char_y),
    .i_obj_x  (bus.obj_x),
    .i_obj_y  (bus.obj_y),
    .i_obj_w  (bus.obj_w),
    .i_obj_h  (bus.obj_h),
    .o_hit    (w_hit),
    .o_dir    (w_dir)
  );

  // Bit 0: address issued this cycle; bit 1: table data for it is on the bus now.
  assign w_cur.vld = r_vld_pipe[1] && bus.obj_valid && (bus.obj_type != TYPE_NONE) && w_hit;
  assign w_cur.typ = bus.obj_type;
  assign w_cur.dir = w_dir;

  // Strict compare keeps the earliest address within a class.
  assign w_nxt = (w_cur.vld && (!r_best.vld || class_prio(w_cur.typ) > class_prio(r_best.typ)))
               ? w_cur : r_best;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_vld_pipe <= '0;
      r_best     <= '0;
      r_col      <= '0;
      r_ctype    <= '0;
    end else begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      r_done        <= 1'b0;
      if (r_vld_pipe[1]) r_best <= w_nxt;
      case (r_state)
        IDLE: if (bus.frame_start) begin
          r_state       <= SCAN;
          r_busy        <= 1'b1;
          r_addr        <= '0;
          r_vld_pipe[0] <= 1'b1;
          r_best        <= '0;
        end
        SCAN: begin
          r_addr <= r_addr + 1'b1;
          if (r_addr == AW'(N_OBJ - 1)) begin
            r_state       <= DRAIN;
            r_vld_pipe[0] <= 1'b0;
          end
        end
        DRAIN: begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_col   <= w_nxt.dir;
          r_ctype <= w_nxt.typ;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.obj_addr       = r_addr;
  assign bus.busy           = r_busy;
  assign bus.scan_done      = r_done;
  assign bus.Collision      = r_col;
  assign bus.Collision_Type = r_ctype;
endmodule

// File: tb/tb_character_collision_scan.sv
// Directed table-driven bench for the collision scanner with a registered object-table model.
module tb_character_collision_scan;
  localparam int N  = 16;
  localparam int CW = 11;

  typedef struct {
    bit en; bit vld; int slot; int x, y, w, h, t;
  } obj_t;

  typedef struct {
    int cx, cy; obj_t a, b; logic [3:0] col; int typ; string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  character_collision_scan_if #(.N_OBJ(N), .COORD_W(CW)) u_if ();

  character_collision_scan #(.N_OBJ(N), .COORD_W(CW), .CHAR_W(16), .CHAR_H(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  logic          tv [N];
  logic [CW-1:0] tx [N], ty [N], tw [N], th [N];
  logic [10:0]   tt [N];

  // Synchronous table: data answers the address presented on the previous edge.
  always @(posedge clk) begin
    u_if.obj_valid <= tv[u_if.obj_addr];
    u_if.obj_x     <= tx[u_if.obj_addr];
    u_if.obj_y     <= ty[u_if.obj_addr];
    u_if.obj_w     <= tw[u_if.obj_addr];
    u_if.obj_h     <= th[u_if.obj_addr];
    u_if.obj_type  <= tt[u_if.obj_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tv[i] = 0; tx[i] = 0; ty[i] = 0; tw[i] = 0; th[i] = 0; tt[i] = 0;
    end
  endtask

  task automatic load(input obj_t o);
    if (o.en) begin
      tv[o.slot] = o.vld;
      tx[o.slot] = CW'(o.x); ty[o.slot] = CW'(o.y);
      tw[o.slot] = CW'(o.w); th[o.slot] = CW'(o.h);
      tt[o.slot] = 11'(o.t);
    end
  endtask

  function automatic obj_t ob(input int slot, x, y, w, h, t);
    obj_t o;
    o.en = 1; o.vld = 1; o.slot = slot; o.x = x; o.y = y; o.w = w; o.h = h; o.t = t;
    return o;
  endfunction

  // Pulses frame_start, then follows cycles 1..N+2; re_at injects a second pulse while busy.
  task automatic run_scan(input int re_at, output int done_cyc, output int errs);
    errs = 0;
    done_cyc = -1;
    @(negedge clk); u_if.frame_start = 1'b1;
    @(negedge clk); u_if.frame_start = 1'b0;
    for (int c = 1; c <= N + 6; c++) begin
      if (c > 1) @(negedge clk);
      u_if.frame_start = (c == re_at);
      if (u_if.busy !== 1'(c <= N + 1)) errs++;
      if (c <= N && u_if.obj_addr !== 4'(c - 1)) errs++;
      if (u_if.scan_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    u_if.frame_start = 1'b0;
  endtask

  vec_t vecs [15];
  obj_t nob, o;
  int   dc, er, quiet;
  logic [3:0]  hold_col;
  logic [10:0] hold_typ;

  initial begin
    nob = '{0, 0, 0, 0, 0, 0, 0, 0};
    o = ob(4, 100, 114, 16, 16, 302); o.vld = 0;
    vecs[0]  = '{100, 100, nob, nob, 4'b0000, 0, "empty"};
    vecs[1]  = '{100, 100, ob(3, 100, 114, 16, 16, 302), nob, 4'b0100, 302, "monster_down"};
    vecs[2]  = '{100, 100, ob(5, 112, 100, 8, 16, 102), nob, 4'b0001, 102, "coin_right"};
    vecs[3]  = '{100, 100, ob(1, 112, 100, 8, 16, 102), ob(9, 100, 114, 16, 16, 302), 4'b0100, 302, "monster_over_coin"};
    vecs[4]  = '{100, 100, ob(2, 116, 100, 8, 16, 102), nob, 4'b0000, 0, "touch_right"};
    vecs[5]  = '{100, 100, ob(2, 100, 100, 16, 16, 0), nob, 4'b0000, 0, "type_zero"};
    vecs[6]  = '{100, 100, ob(4, 90, 100, 12, 16, 500), ob(7, 100, 114, 16, 16, 600), 4'b0010, 500, "lowest_addr"};
    vecs[7]  = '{100, 100, ob(6, 100, 90, 16, 12, 7), nob, 4'b1000, 7, "solid_up"};
    vecs[8]  = '{100, 100, ob(0, 100, 100, 16, 16, 302), nob, 4'b0100, 302, "tie_all"};
    vecs[9]  = '{100, 100, ob(0, 100, 114, 16, 16, 33), ob(15, 112, 100, 8, 16, 102), 4'b0001, 102, "last_slot_coin"};
    vecs[10] = '{2040, 100, ob(8, 2045, 100, 2, 16, 5), nob, 4'b0010, 5, "no_wrap"};
    vecs[11] = '{100, 100, ob(12, 100, 50, 16, 100, 9), nob, 4'b0010, 9, "tie_lr"};
    vecs[12] = '{100, 100, o, nob, 4'b0000, 0, "invalid_slot"};
    vecs[13] = '{100, 100, ob(10, 100, 116, 16, 16, 302), nob, 4'b0000, 0, "touch_bottom"};
    vecs[14] = '{100, 100, ob(2, 100, 90, 16, 12, 302), ob(11, 100, 114, 16, 16, 302), 4'b1000, 302, "two_monsters"};

    clear_table();
    u_if.frame_start = 1'b0;
    u_if.char_x = CW'(100);
    u_if.char_y = CW'(100);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_done", 32'(u_if.scan_done), 0);
    chk("rst_col", 32'(u_if.Collision), 0);
    chk("rst_type", 32'(u_if.Collision_Type), 0);
    chk("rst_addr", 32'(u_if.obj_addr), 0);

    for (int i = 0; i < 15; i++) begin
      clear_table();
      load(vecs[i].a);
      load(vecs[i].b);
      u_if.char_x = CW'(vecs[i].cx);
      u_if.char_y = CW'(vecs[i].cy);
      run_scan(0, dc, er);
      chk({vecs[i].name, "_done_cyc"}, 32'(dc), N + 2);
      chk({vecs[i].name, "_seq_errs"}, 32'(er), 0);
      chk({vecs[i].name, "_col"}, 32'(u_if.Collision), 32'(vecs[i].col));
      chk({vecs[i].name, "_type"}, 32'(u_if.Collision_Type), 32'(vecs[i].typ));
    end

    // Outputs hold, and a frame_start while busy is dropped rather than queued.
    clear_table();
    load(ob(5, 112, 100, 8, 16, 102));
    u_if.char_x = CW'(100);
    u_if.char_y = CW'(100);
    run_scan(5, dc, er);
    chk("ignore_done_cyc", 32'(dc), N + 2);
    chk("ignore_seq_errs", 32'(er), 0);
    hold_col = u_if.Collision;
    hold_typ = u_if.Collision_Type;
    chk("ignore_col", 32'(hold_col), 32'(4'b0001));
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (u_if.busy !== 1'b0 || u_if.scan_done !== 1'b0) quiet++;
    end
    chk("ignore_no_restart", 32'(quiet), 0);
    chk("hold_col", 32'(u_if.Collision), 32'(hold_col));
    chk("hold_type", 32'(u_if.Collision_Type), 32'(hold_typ));

    // Reset in cycle 8 of a scan aborts it; outputs currently hold the coin result.
    clear_table();
    load(ob(3, 100, 114, 16, 16, 302));
    @(negedge clk); u_if.frame_start = 1'b1;
    @(negedge clk); u_if.frame_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", 32'(u_if.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(u_if.busy), 0);
    chk("midrst_done", 32'(u_if.scan_done), 0);
    chk("midrst_col", 32'(u_if.Collision), 0);
    chk("midrst_type", 32'(u_if.Collision_Type), 0);
    chk("midrst_addr", 32'(u_if.obj_addr), 0);
    quiet = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (u_if.scan_done !== 1'b0 || u_if.busy !== 1'b0) quiet++;
    end
    chk("midrst_no_done", 32'(quiet), 0);
    run_scan(0, dc, er);
    chk("post_rst_done_cyc", 32'(dc), N + 2);
    chk("post_rst_seq_errs", 32'(er), 0);
    chk("post_rst_col", 32'(u_if.Collision), 32'(4'b0100));
    chk("post_rst_type", 32'(u_if.Collision_Type), 302);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
